reg_file: RTL and testbench

- 32 x 32-bit general-purpose register file for the non-pipelined MIPS datapath.
- Sits directly upstream of the ALU and drives its in1/in2 operands.
- Two synchronous read ports, one write port, write-to-read bypass, $0 hardwired to zero.
- Outputs are registered, so operands are stable before the ALU's posedge sample.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/reg_read_port.sv | 63 ++++++
 rtl/reg_file.sv | 100 ++++++++++
 tb/tb_reg_file.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the non-pipelined MIPS datapath. The register
// file, the instruction decoder and the ALU control all import this package so
// that register-address and data-word widths are defined in exactly one place.
//
// Contents:
//   DATA_W     - width of a datapath word / register
//   ADDR_W     - width of a register specifier (rs/rt/rd)
//   NUM_REGS   - number of architectural registers (2**ADDR_W)
//   REG_ZERO   - specifier of the hardwired-zero register $0
//   reg_addr_t - register specifier type
//   word_t     - datapath word, bit 0 is the MSB to match ALU operand ordering
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [0:DATA_W-1] word_t;

endpackage : mips_pkg

// File: rtl/reg_read_port.sv
// -----------------------------------------------------------------------------
// reg_read_port
// One synchronous read port of the register file. Selects the addressed entry
// from the array, forces $0 to zero, forwards the write data when the same
// cycle writes the register being read, and registers the result so the ALU
// sees a stable operand.
//
// Ports:
//   clk    in   clock, all updates on posedge
//   rst_n  in   asynchronous active-low reset, clears the output register
//   rd_en  in   read request; when low the output register holds
//   ra     in   read address
//   we     in   write enable of the shared write port (for the bypass)
//   wa     in   write address of the shared write port
//   wd     in   write data of the shared write port
//   regs   in   current contents of the register array
//   rd     out  registered read data
// -----------------------------------------------------------------------------
module reg_read_port
   import mips_pkg::*;
#(
   parameter int DATA_W   = mips_pkg::DATA_W,
   parameter int ADDR_W   = mips_pkg::ADDR_W,
   parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] ra,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [0:DATA_W-1] wd,
   input  logic [0:DATA_W-1] regs [NUM_REGS],
   output logic [0:DATA_W-1] rd
);

   logic [0:DATA_W-1] rd_next;

   // Priority: $0 always reads zero, then the in-flight write (write-first),
   // then the stored value. The zero check must win over the bypass even
   // though a write to $0 is dropped, since wd is arbitrary in that case.
   // NOTE: every combinational output gets a default first so no path through
   // the block leaves it unassigned, which would infer a latch.
   always_comb begin
      rd_next = regs[ra];
      if (ra == ADDR_W'(REG_ZERO)) begin
         rd_next = '0;
      end else if (we && (wa == ra)) begin
         rd_next = wd;
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd <= '0;
      end else if (rd_en) begin
         rd <= rd_next;
      end
   end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 32 x 32-bit general-purpose register file for the non-pipelined MIPS
// datapath. Two registered read ports feed ALU in1/in2; one write port takes
// the ALU result or memory data. $0 is hardwired to zero and a write to the
// register being read in the same cycle is forwarded to the read data.
//
// Ports:
//   clk       in   clock, all updates on posedge
//   rst_n     in   asynchronous active-low reset, clears array and outputs
//   rd_en     in   read request; ra1/ra2 are sampled on this edge
//   ra1       in   read address, port 1 (rs)
//   ra2       in   read address, port 2 (rt)
//   we        in   write enable
//   wa        in   write address (rd/rt)
//   wd        in   write data
//   rd1       out  registered read data, port 1 (ALU in1)
//   rd2       out  registered read data, port 2 (ALU in2)
//   rd_valid  out  one-cycle pulse, one cycle after an accepted rd_en
// -----------------------------------------------------------------------------
module reg_file
   import mips_pkg::*;
#(
   parameter int DATA_W   = mips_pkg::DATA_W,
   parameter int ADDR_W   = mips_pkg::ADDR_W,
   parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [0:DATA_W-1] wd,
   output logic [0:DATA_W-1] rd1,
   output logic [0:DATA_W-1] rd2,
   output logic              rd_valid
);

   logic [0:DATA_W-1] regs [NUM_REGS];

   // Writes are qualified by we first, so an unknown wa while we is low can
   // never select an entry. Writes to $0 are dropped, keeping entry 0 at the
   // zero it was given at reset.
   // NOTE: the array is built from flops and cleared by the asynchronous
   // reset because the architecture requires every register to read zero
   // after reset; an SRAM macro could not provide that.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (wa != ADDR_W'(REG_ZERO))) begin
         regs[wa] <= wd;
      end
   end

   // The only control state: a one-deep pipeline flag tracking the read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
      end
   end

   reg_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_port1 (
      .clk   (clk),
      .rst_n (rst_n),
      .rd_en (rd_en),
      .ra    (ra1),
      .we    (we),
      .wa    (wa),
      .wd    (wd),
      .regs  (regs),
      .rd    (rd1)
   );

   reg_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_port2 (
      .clk   (clk),
      .rst_n (rst_n),
      .rd_en (rd_en),
      .ra    (ra2),
      .we    (we),
      .wa    (wa),
      .wd    (wd),
      .regs  (regs),
      .rd    (rd2)
   );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Directed and randomized stimulus for reg_file, checked against an array
// model of the architectural registers and the read rules of the register
// file (zero register, write-first forwarding, hold when not reading).
// -----------------------------------------------------------------------------
module tb_reg_file;

   logic        clk;
   logic        rst_n;
   logic        rd_en;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        rd_valid;

   // Reference state.
   logic [31:0] mem [32];
   logic [31:0] exp_rd1;
   logic [31:0] exp_rd2;
   logic        exp_valid;

   int n_cmp;
   int n_bad;

   reg_file dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en),
      .ra1      (ra1),
      .ra2      (ra2),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .rd1      (rd1),
      .rd2      (rd2),
      .rd_valid (rd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Architectural value seen by a read of register a in the current cycle.
   function automatic logic [31:0] ref_value(input logic [4:0] a, input logic w,
                                             input logic [4:0] wa_i, input logic [31:0] d);
      if (a == 5'd0) return 32'd0;
      if (w === 1'b1 && wa_i == a) return d;
      return mem[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      exp_rd1   = 32'd0;
      exp_rd2   = 32'd0;
      exp_valid = 1'b0;
   endtask

   // Apply one cycle of inputs, advance the model, then compare just after
   // the edge.
   task automatic cycle(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic w, input logic [4:0] a, input logic [31:0] d,
                        input string tag);
      rd_en = r;
      ra1   = a1;
      ra2   = a2;
      we    = w;
      wa    = a;
      wd    = d;
      if (r) begin
         exp_rd1 = ref_value(a1, w, a, d);
         exp_rd2 = ref_value(a2, w, a, d);
      end
      exp_valid = r;
      if (w === 1'b1) begin
         if (a != 5'd0) mem[a] = d;
      end
      @(posedge clk);
      #1;
      check({tag, ".rd1"}, rd1, exp_rd1);
      check({tag, ".rd2"}, rd2, exp_rd2);
      check({tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, exp_valid});
   endtask

   task automatic idle(input string tag);
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, tag);
   endtask

   // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
   task automatic reset_pulse(input int cycles, input string tag);
      rd_en = 1'b0;
      we    = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check({tag, ".async_rd1"}, rd1, 32'd0);
      check({tag, ".async_rd2"}, rd2, 32'd0);
      check({tag, ".async_valid"}, {31'd0, rd_valid}, 32'd0);
      repeat (cycles) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [4:0]  r1, r2, wa_r;
      logic [31:0] d;
      logic        r, w;

      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      rd_en = 1'b0;
      ra1   = '0;
      ra2   = '0;
      we    = 1'b0;
      wa    = '0;
      wd    = '0;
      model_clear();

      repeat (2) @(posedge clk);
      #1;
      check("por.rd1", rd1, 32'd0);
      check("por.rd2", rd2, 32'd0);
      check("por.valid", {31'd0, rd_valid}, 32'd0);
      #1;
      rst_n = 1'b1;

      // 1. Make outputs and registers nonzero, then reset mid-cycle.
      cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hA5A5_0005, "pre_w5");
      cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 32'h1234_5678, "pre_w31");
      cycle(1'b1, 5'd5, 5'd31, 1'b0, 5'd0, 32'd0, "pre_rd");
      reset_pulse(1, "rst1");
      cycle(1'b1, 5'd5, 5'd31, 1'b0, 5'd0, 32'd0, "rst1_rd");

      // 2. Write then read, valid pulse then hold.
      cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h0000_0007, "w3");
      cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h0000_0003, "w4");
      cycle(1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, "rd34");
      idle("rd34_after");

      // 3. $0 protection.
      cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, "w0");
      cycle(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, "rd0");
      // Read $0 while writing it in the same cycle: no bypass for $0.
      cycle(1'b1, 5'd0, 5'd3, 1'b1, 5'd0, 32'hFFFF_FFFF, "rd0_w0");

      // 4. Bypass on both ports, then array holds the new value.
      cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 32'h0000_0011, "w8a");
      cycle(1'b1, 5'd8, 5'd8, 1'b1, 5'd8, 32'h0000_0022, "byp8");
      cycle(1'b1, 5'd8, 5'd4, 1'b0, 5'd0, 32'd0, "rd8");

      // 5. Hold while idle, writes do not disturb read data.
      cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 32'h0000_000C, "w2");
      cycle(1'b1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0, "rd2");
      cycle(1'b0, 5'd2, 5'd1, 1'b1, 5'd1, 32'h0000_0099, "hold_w1");
      cycle(1'b0, 5'd1, 5'd2, 1'b1, 5'd2, 32'h0000_0055, "hold_w2");
      idle("hold_idle");
      cycle(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, "rd12");

      // Unknown write address with we low must not corrupt anything.
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 5'bxxxxx, 32'hBAD0_BAD0, "wa_x");
      cycle(1'b1, 5'd1, 5'd8, 1'b0, 5'd0, 32'd0, "rd_after_x");
      cycle(1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, "rd34_after_x");

      // 6. Reset mid-operation clears the array.
      cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd12, 32'd12, "w12");
      cycle(1'b1, 5'd12, 5'd8, 1'b0, 5'd0, 32'd0, "rd12_pre");
      reset_pulse(1, "rst2");
      cycle(1'b1, 5'd12, 5'd8, 1'b0, 5'd0, 32'd0, "rd12_post");

      // Randomized traffic; write address biased towards the read addresses
      // so forwarding is exercised often.
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 3) != 0);
         w  = ($urandom_range(0, 2) != 0);
         r1 = 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 7) == 0) ? r1 : 5'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0:       wa_r = r1;
            1:       wa_r = r2;
            default: wa_r = 5'($urandom_range(0, 31));
         endcase
         d = $urandom;
         cycle(r, r1, r2, w, wa_r, d, "rand");
      end

      // Final sweep of every register through both ports.
      for (int i = 0; i < 32; i++) begin
         cycle(1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'd0, "sweep");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_reg_file
